// File: rtl/btn_debounce.sv
// Per-channel button debouncer. Buttons are sampled on a one-clk strobe taken
// from the slow clk_4ms square wave, and a level change is accepted only after
// STABLE_TICKS consecutive equal samples.
module btn_debounce #(
  parameter int NBTN         = 4,
  parameter int STABLE_TICKS = 5,
  parameter int ACTIVE_HIGH  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_4ms,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release,
  output logic            tick
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM_PRESS = 2'd1,
    HELD      = 2'd2,
    ARM_REL   = 2'd3
  } state_t;

  localparam logic [2:0] STABLE = 3'(STABLE_TICKS);

  logic [1:0]      slow_sync;
  logic            slow_prev;
  logic            slow_seen_low;
  logic [1:0]      warm;
  logic [NBTN-1:0] raw_meta;
  logic [NBTN-1:0] raw_sync;
  logic [NBTN-1:0] sample;

  state_t          state     [NBTN];
  state_t          state_nxt [NBTN];
  logic [2:0]      cnt       [NBTN];
  logic [2:0]      cnt_nxt   [NBTN];
  logic [NBTN-1:0] press_nxt;
  logic [NBTN-1:0] release_nxt;

  assign sample = (ACTIVE_HIGH != 0) ? raw_sync : ~raw_sync;

  // A rising edge only counts once the synchronized clk_4ms has been seen low
  // after reset, so a level already high at reset release cannot fire a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      slow_sync     <= '0;
      slow_prev     <= 1'b0;
      slow_seen_low <= 1'b0;
      warm          <= '0;
      tick          <= 1'b0;
      raw_meta      <= '0;
      raw_sync      <= '0;
      btn_press     <= '0;
      btn_release   <= '0;
      for (int unsigned i = 0; i < NBTN; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      slow_sync     <= {slow_sync[0], clk_4ms};
      slow_prev     <= slow_sync[1];
      warm          <= {warm[0], 1'b1};
      slow_seen_low <= slow_seen_low | (warm[1] & ~slow_sync[1]);
      tick          <= slow_sync[1] & ~slow_prev & slow_seen_low;
      raw_meta      <= btn_raw;
      raw_sync      <= raw_meta;
      btn_press     <= press_nxt;
      btn_release   <= release_nxt;
      for (int unsigned i = 0; i < NBTN; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NBTN; i++) begin
      state_nxt[i]   = state[i];
      cnt_nxt[i]     = cnt[i];
      press_nxt[i]   = 1'b0;
      release_nxt[i] = 1'b0;
      btn_level[i]   = (state[i] == HELD) || (state[i] == ARM_REL);
      if (tick) begin
        unique case (state[i])
          IDLE: begin
            if (sample[i]) begin
              state_nxt[i] = ARM_PRESS;
              cnt_nxt[i]   = 3'd1;
            end
          end
          ARM_PRESS: begin
            if (!sample[i]) begin
              state_nxt[i] = IDLE;
              cnt_nxt[i]   = '0;
            end else if ((cnt[i] + 3'd1) == STABLE) begin
              state_nxt[i] = HELD;
              cnt_nxt[i]   = '0;
              press_nxt[i] = 1'b1;
            end else begin
              cnt_nxt[i]   = cnt[i] + 3'd1;
            end
          end
          HELD: begin
            if (!sample[i]) begin
              state_nxt[i] = ARM_REL;
              cnt_nxt[i]   = 3'd1;
            end
          end
          ARM_REL: begin
            if (sample[i]) begin
              state_nxt[i] = HELD;
              cnt_nxt[i]   = '0;
            end else if ((cnt[i] + 3'd1) == STABLE) begin
              state_nxt[i]   = IDLE;
              cnt_nxt[i]     = '0;
              release_nxt[i] = 1'b1;
            end else begin
              cnt_nxt[i]     = cnt[i] + 3'd1;
            end
          end
          default: begin
            state_nxt[i] = IDLE;
            cnt_nxt[i]   = '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: one active-high and one active-low instance
// share clk/rst/clk_4ms; expected pulses are queued and checked every cycle.
module tb_btn_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_4ms;
  logic [3:0] btn_raw, btn_raw2;
  logic [3:0] level, press, release_p;
  logic [3:0] level2, press2, release2;
  logic       tick, tick2;

  typedef struct {
    int         cyc;
    int         unit_id;
    logic [3:0] press;
    logic [3:0] rel;
  } ev_t;

  ev_t        sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cycle  = 0;
  bit         slow_run;
  logic [3:0] exp_level [2];
  int         tick_from  = 33;
  int         tick_until = 1400;

  always #5 clk = ~clk;

  btn_debounce #(.NBTN(4), .STABLE_TICKS(5), .ACTIVE_HIGH(1)) dut (
    .clk(clk), .rst(rst), .clk_4ms(clk_4ms), .btn_raw(btn_raw),
    .btn_level(level), .btn_press(press), .btn_release(release_p), .tick(tick)
  );

  btn_debounce #(.NBTN(4), .STABLE_TICKS(5), .ACTIVE_HIGH(0)) dut_al (
    .clk(clk), .rst(rst), .clk_4ms(clk_4ms), .btn_raw(btn_raw2),
    .btn_level(level2), .btn_press(press2), .btn_release(release2), .tick(tick2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d got %h expected %h", tag, cycle, got, exp);
    end
  endtask

  task automatic push(input int c, input int u, input logic [3:0] p, input logic [3:0] r);
    ev_t e;
    e.cyc = c; e.unit_id = u; e.press = p; e.rel = r;
    sb.push_back(e);
  endtask

  // One clk: sample outputs just after the edge, compare, then advance clk_4ms.
  task automatic cyc();
    logic [3:0] ep [2];
    logic [3:0] er [2];
    logic       exp_tick;
    ev_t        keep[$];
    @(posedge clk);
    #1;
    cycle++;
    ep[0] = '0; ep[1] = '0; er[0] = '0; er[1] = '0;
    if (rst) begin
      exp_level[0] = '0;
      exp_level[1] = '0;
    end
    foreach (sb[k]) begin
      if (sb[k].cyc == cycle) begin
        ep[sb[k].unit_id] = ep[sb[k].unit_id] | sb[k].press;
        er[sb[k].unit_id] = er[sb[k].unit_id] | sb[k].rel;
      end else begin
        keep.push_back(sb[k]);
      end
    end
    sb = keep;
    for (int u = 0; u < 2; u++)
      exp_level[u] = (exp_level[u] | ep[u]) & ~er[u];
    exp_tick = (cycle >= tick_from) && (cycle < tick_until) && (cycle % 20 == 13);
    chk("tick",     {31'd0, tick},  {31'd0, exp_tick});
    chk("tick_al",  {31'd0, tick2}, {31'd0, exp_tick});
    chk("press",    {28'd0, press},     {28'd0, ep[0]});
    chk("release",  {28'd0, release_p}, {28'd0, er[0]});
    chk("level",    {28'd0, level},     {28'd0, exp_level[0]});
    chk("press_al", {28'd0, press2},    {28'd0, ep[1]});
    chk("rel_al",   {28'd0, release2},  {28'd0, er[1]});
    chk("level_al", {28'd0, level2},    {28'd0, exp_level[1]});
    if (slow_run && (cycle % 10 == 0)) clk_4ms = ~clk_4ms;
  endtask

  task automatic run_to(input int c);
    while (cycle < c) cyc();
  endtask

  initial begin
    rst      = 1'b1;
    clk_4ms  = 1'b0;
    btn_raw  = 4'b1000;
    btn_raw2 = 4'hF;
    slow_run = 1'b1;
    exp_level[0] = '0;
    exp_level[1] = '0;

    // Button 3 held through reset release, clk_4ms high at release.
    push(114, 0, 4'h8, 4'h0);
    run_to(12);
    rst = 1'b0;
    run_to(123); btn_raw[3] = 1'b0; push(214, 0, 4'h0, 4'h8);

    // Basic press/release on channel 0.
    run_to(243); btn_raw[0] = 1'b1; push(334, 0, 4'h1, 4'h0);
    run_to(403); btn_raw[0] = 1'b0; push(494, 0, 4'h0, 4'h1);

    // Bounce on channel 1: three high samples, one low, then held.
    run_to(503); btn_raw[1] = 1'b1;
    run_to(563); btn_raw[1] = 1'b0;
    run_to(583); btn_raw[1] = 1'b1; push(674, 0, 4'h2, 4'h0);
    run_to(703); btn_raw[1] = 1'b0; push(794, 0, 4'h0, 4'h2);

    // Short glitch between ticks on channel 2.
    run_to(803); btn_raw[2] = 1'b1;
    run_to(807); btn_raw[2] = 1'b0;

    // All channels together.
    run_to(823); btn_raw = 4'hF; push(914, 0, 4'hF, 4'h0);
    run_to(943); btn_raw = 4'h0; push(1034, 0, 4'h0, 4'hF);

    // Reset in the middle of a press count.
    run_to(1043); btn_raw[0] = 1'b1;
    run_to(1100); rst = 1'b1;
    run_to(1102);
    chk("rst_mid_level", {28'd0, level}, 32'd0);
    chk("rst_mid_tick",  {31'd0, tick},  32'd0);
    rst = 1'b0;
    push(1194, 0, 4'h1, 4'h0);
    run_to(1203); btn_raw[0] = 1'b0; push(1294, 0, 4'h0, 4'h1);

    // Active-low instance, then freeze clk_4ms high.
    run_to(1303); btn_raw2[2] = 1'b0; push(1394, 1, 4'h4, 4'h0);
    run_to(1399); slow_run = 1'b0;
    run_to(1403); btn_raw2[2] = 1'b1; btn_raw[1] = 1'b1;
    run_to(1600);
    chk("frozen_level_al", {28'd0, level2}, 32'h4);
    chk("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
